// File: rtl/instruction_fetch_unit.sv
// Walks the instruction RAM from address 0 and hands each word downstream over valid/ready.
// Two edges per word with ready high; a word is held with valid asserted for as long as ready stays low.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] END_OF_PROGRAM = 8'hFF,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDRESS   = 8'd255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_index,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic                    valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                    end
                end
                S_FETCH: begin
                    // RAM is combinational, so its output is valid on this same edge.
                    if (mem_data == END_OF_PROGRAM) begin
                        state_q <= S_DONE;
                    end else begin
                        instr_q <= mem_data;
                        index_q <= pc_q;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (pc_q == LAST_ADDRESS) begin
                            state_q <= S_ERROR;
                        end else begin
                            pc_q    <= pc_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_address = pc_q;
    assign mem_enable  = (state_q == S_FETCH);
    assign instr       = instr_q;
    assign instr_index = index_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);

endmodule
